load_align: RTL and testbench

Memory-stage load responder. Takes the load requests the execute stage issues (address, size, split/second-half marking) and the raw 32-bit words returned by data memory one cycle later. Extracts and right-justifies the addressed bytes. Merges the two halves of a misaligned word/double access into one result. Emits a single registered load result per load instruction toward writeback.

---
 rtl/load_align.sv | 170 +++++++++++++++++
 tb/tb_load_align.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_align.sv
// load_align -- memory-stage load responder.
//
// Captures load requests from execute (stage A), aligns the memory word that
// returns one cycle later (stage B), merges the two halves of a misaligned
// word/double access, and emits one registered result per load instruction.
//
// Optional feature macro: LOAD_SEXT_EN
//   defined   -> req_signed=1 sign-extends byte (bit 7) and double (bit 15)
//                results.
//   undefined -> req_signed is ignored; every result is zero-extended.
//
// Ports:
//   clk, rst       clock; synchronous active-high reset (overrides enables)
//   clk_en, halt   state advances only when clk_en=1 and halt=0
//   req_valid      load request present this cycle
//   req_opcode     3-5 word, 6-8 double (16-bit), 9-11 byte, others word
//   req_off        addr[1:0] of the original (unsplit) access
//   req_split      first half of a misaligned access
//   req_second     second half of a misaligned access
//   req_signed     sign-extend request (LOAD_SEXT_EN only)
//   req_kill       cancels stage A, any held half, and any result on this edge
//   mem_rdata      memory word for the request captured on the previous edge
//   rsp_valid      result valid pulse (held while frozen)
//   rsp_data       aligned, extended result; retains value when not valid
//   rsp_err        protocol violation pulse (orphan second half / overwrite)
//
// Handshake: no back-pressure. A request is taken on every enabled edge where
// req_valid=1; the consumer samples rsp_valid/rsp_data/rsp_err only on enabled
// edges, so a pulse that spans frozen cycles still counts once.
module load_align (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_en,
    input  logic        halt,
    input  logic        req_valid,
    input  logic [4:0]  req_opcode,
    input  logic [1:0]  req_off,
    input  logic        req_split,
    input  logic        req_second,
    input  logic        req_signed,
    input  logic        req_kill,
    input  logic [31:0] mem_rdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_err
);

    typedef enum logic [1:0] {
        SZ_WORD = 2'd0,
        SZ_HALF = 2'd1,
        SZ_BYTE = 2'd2
    } size_t;

    typedef enum logic {
        IDLE = 1'b0,
        HELD = 1'b1
    } state_t;

    // Stage A: captured request fields
    logic       a_valid;
    size_t      a_size;
    logic [1:0] a_off;
    logic       a_split;
    logic       a_second;
    logic       a_signed;

    // Split-merge state
    state_t      state;
    logic [31:0] hold;

    logic        en;
    size_t       req_size;
    logic [31:0] low_part;
    logic [31:0] merged;
    logic [5:0]  hi_shift;

    assign en = clk_en & ~halt;

    always_comb begin
        req_size = SZ_WORD;
        case (req_opcode)
            5'd6, 5'd7, 5'd8:  req_size = SZ_HALF;
            5'd9, 5'd10, 5'd11: req_size = SZ_BYTE;
            default:           req_size = SZ_WORD;
        endcase
    end

    // Lanes off..3 moved down to bytes 0..3-off. Serves both aligned loads
    // and the first half of a split (vacated upper bytes become zero).
    assign low_part = mem_rdata >> {a_off, 3'b000};

    // Second half: lanes 0..off-1 land at bytes 4-off..3. For a double with
    // off=3 this puts lane 0 at byte 1; masking to 16 bits happens in extend.
    assign hi_shift = {3'd4 - {1'b0, a_off}, 3'b000};
    assign merged   = hold | (mem_rdata << hi_shift);

`ifdef LOAD_SEXT_EN
    logic use_sext;
    assign use_sext = a_signed;
`else
    logic use_sext;
    logic sext_unused;
    assign use_sext    = 1'b0;
    assign sext_unused = a_signed;
`endif

    function automatic logic [31:0] extend(input logic [31:0] d,
                                           input size_t sz,
                                           input logic sx);
        logic [31:0] r;
        case (sz)
            SZ_BYTE: r = {{24{sx & d[7]}}, d[7:0]};
            SZ_HALF: r = {{16{sx & d[15]}}, d[15:0]};
            default: r = d;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            a_valid   <= 1'b0;
            a_size    <= SZ_WORD;
            a_off     <= 2'd0;
            a_split   <= 1'b0;
            a_second  <= 1'b0;
            a_signed  <= 1'b0;
            state     <= IDLE;
            hold      <= 32'd0;
            rsp_valid <= 1'b0;
            rsp_data  <= 32'd0;
            rsp_err   <= 1'b0;
        end else if (en) begin
            // Stage A capture; a kill drops the request being presented.
            a_valid  <= req_valid & ~req_kill;
            a_size   <= req_size;
            a_off    <= req_off;
            a_split  <= req_split;
            a_second <= req_second;
            a_signed <= req_signed;

            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;

            // Stage B: a kill on this edge suppresses whatever stage A holds.
            if (a_valid && !req_kill) begin
                if (a_second) begin
                    if (state == HELD) begin
                        rsp_valid <= 1'b1;
                        rsp_data  <= extend(merged, a_size, use_sext);
                        state     <= IDLE;
                    end else begin
                        rsp_err <= 1'b1;   // orphan second half
                    end
                end else if (a_split) begin
                    hold  <= low_part;
                    state <= HELD;
                    if (state == HELD)
                        rsp_err <= 1'b1;   // earlier first half overwritten
                end else begin
                    rsp_valid <= 1'b1;
                    rsp_data  <= extend(low_part, a_size, use_sext);
                end
            end

            if (req_kill)
                state <= IDLE;
        end
    end

endmodule

// File: tb/tb_load_align.sv
// Directed testbench for load_align. Inputs are driven 1 time unit after the
// rising edge; outputs are checked at that same point, i.e. away from the edge.
module tb_load_align;

    logic        clk;
    logic        rst;
    logic        clk_en;
    logic        halt;
    logic        req_valid;
    logic [4:0]  req_opcode;
    logic [1:0]  req_off;
    logic        req_split;
    logic        req_second;
    logic        req_signed;
    logic        req_kill;
    logic [31:0] mem_rdata;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;

    int n_cmp;
    int n_bad;

    localparam logic [4:0] OP_WORD = 5'd3;
    localparam logic [4:0] OP_HALF = 5'd6;
    localparam logic [4:0] OP_BYTE = 5'd9;

    load_align dut (
        .clk        (clk),
        .rst        (rst),
        .clk_en     (clk_en),
        .halt       (halt),
        .req_valid  (req_valid),
        .req_opcode (req_opcode),
        .req_off    (req_off),
        .req_split  (req_split),
        .req_second (req_second),
        .req_signed (req_signed),
        .req_kill   (req_kill),
        .mem_rdata  (mem_rdata),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- drivers ----------------
    task automatic drive_req(input logic [4:0] op, input logic [1:0] off,
                             input logic split, input logic second,
                             input logic sgn);
        req_valid  = 1'b1;
        req_opcode = op;
        req_off    = off;
        req_split  = split;
        req_second = second;
        req_signed = sgn;
    endtask

    task automatic drive_idle();
        req_valid  = 1'b0;
        req_opcode = 5'd0;
        req_off    = 2'd0;
        req_split  = 1'b0;
        req_second = 1'b0;
        req_signed = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; clk_en = 1'b0; halt = 1'b1; req_kill = 1'b0;
        mem_rdata = 32'hFFFF_FFFF;
        drive_req(OP_WORD, 2'd0, 1'b0, 1'b0, 1'b0);
        step(); step(); step();
        n_cmp++;
        if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_data !== 32'd0) begin
            n_bad++;
            $display("FAIL reset: valid=%b err=%b data=%h, want 0/0/00000000",
                     rsp_valid, rsp_err, rsp_data);
        end
        rst = 1'b0; clk_en = 1'b1; halt = 1'b0;
        drive_idle();
        step(); step();
        n_cmp++;
        if (rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin
            n_bad++;
            $display("FAIL post_reset_quiet: valid=%b err=%b, want 0/0", rsp_valid, rsp_err);
        end
    endtask

    task automatic test_aligned_word();
        drive_req(OP_WORD, 2'd0, 1'b0, 1'b0, 1'b0);
        step();
        drive_idle();
        mem_rdata = 32'hDDCC_BBAA;
        n_cmp++;
        if (rsp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL word_early: valid=%b want 0", rsp_valid);
        end
        step();
        mem_rdata = 32'h1234_5678;
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'hDDCC_BBAA) begin
            n_bad++;
            $display("FAIL word_rsp: valid=%b data=%h want 1 ddccbbaa", rsp_valid, rsp_data);
        end
        step();
        n_cmp++;
        if (rsp_valid !== 1'b0 || rsp_data !== 32'hDDCC_BBAA) begin
            n_bad++;
            $display("FAIL word_pulse_end: valid=%b data=%h want 0 ddccbbaa", rsp_valid, rsp_data);
        end
    endtask

    task automatic test_back_to_back();
        drive_req(OP_BYTE, 2'd2, 1'b0, 1'b0, 1'b0);
        step();
        drive_req(OP_BYTE, 2'd3, 1'b0, 1'b0, 1'b0);
        mem_rdata = 32'h4433_2211;
        step();
        drive_idle();
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'h0000_0033) begin
            n_bad++;
            $display("FAIL byte_off2: valid=%b data=%h want 1 00000033", rsp_valid, rsp_data);
        end
        step();
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'h0000_0044) begin
            n_bad++;
            $display("FAIL byte_off3: valid=%b data=%h want 1 00000044", rsp_valid, rsp_data);
        end
        step();
        n_cmp++;
        if (rsp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_end: valid=%b want 0", rsp_valid);
        end
    endtask

    task automatic test_double_aligned();
        drive_req(OP_HALF, 2'd1, 1'b0, 1'b0, 1'b0);
        step();
        drive_idle();
        mem_rdata = 32'h4433_2211;
        step();
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'h0000_3322) begin
            n_bad++;
            $display("FAIL double_off1: valid=%b data=%h want 1 00003322", rsp_valid, rsp_data);
        end
        step();
    endtask

    task automatic test_split_word();
        drive_req(OP_WORD, 2'd1, 1'b1, 1'b0, 1'b0);
        step();
        drive_req(OP_WORD, 2'd1, 1'b0, 1'b1, 1'b0);
        mem_rdata = 32'h4433_2211;
        step();
        drive_idle();
        mem_rdata = 32'h8877_6655;
        n_cmp++;
        if (rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin
            n_bad++;
            $display("FAIL split_word_n2: valid=%b err=%b want 0/0", rsp_valid, rsp_err);
        end
        step();
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'h5544_3322 || rsp_err !== 1'b0) begin
            n_bad++;
            $display("FAIL split_word_n3: valid=%b data=%h err=%b want 1 55443322 0",
                     rsp_valid, rsp_data, rsp_err);
        end
        step();
        n_cmp++;
        if (rsp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL split_word_once: valid=%b want 0", rsp_valid);
        end
    endtask

    task automatic test_split_double();
        drive_req(OP_HALF, 2'd3, 1'b1, 1'b0, 1'b0);
        step();
        drive_req(OP_HALF, 2'd3, 1'b0, 1'b1, 1'b0);
        mem_rdata = 32'h4433_2211;
        step();
        drive_idle();
        mem_rdata = 32'h8877_6655;
        step();
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'h0000_5544) begin
            n_bad++;
            $display("FAIL split_double: valid=%b data=%h want 1 00005544", rsp_valid, rsp_data);
        end
        step();
    endtask

    task automatic test_sign_ext();
        logic [31:0] exp_byte;
        logic [31:0] exp_half;
`ifdef LOAD_SEXT_EN
        exp_byte = 32'hFFFF_FF80;
        exp_half = 32'hFFFF_8001;
`else
        exp_byte = 32'h0000_0080;
        exp_half = 32'h0000_8001;
`endif
        drive_req(OP_BYTE, 2'd0, 1'b0, 1'b0, 1'b1);
        step();
        drive_req(OP_HALF, 2'd2, 1'b0, 1'b0, 1'b1);
        mem_rdata = 32'h0000_0080;
        step();
        drive_idle();
        mem_rdata = 32'h8001_7F7F;
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_data !== exp_byte) begin
            n_bad++;
            $display("FAIL sext_byte: valid=%b data=%h want 1 %h", rsp_valid, rsp_data, exp_byte);
        end
        step();
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_data !== exp_half) begin
            n_bad++;
            $display("FAIL sext_half: valid=%b data=%h want 1 %h", rsp_valid, rsp_data, exp_half);
        end
        // Unsigned byte with bit 7 set stays zero-extended in either build.
        drive_req(OP_BYTE, 2'd0, 1'b0, 1'b0, 1'b0);
        step();
        drive_idle();
        mem_rdata = 32'h0000_0080;
        step();
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'h0000_0080) begin
            n_bad++;
            $display("FAIL zext_byte: valid=%b data=%h want 1 00000080", rsp_valid, rsp_data);
        end
        step();
    endtask

    task automatic test_orphan();
        drive_req(OP_WORD, 2'd1, 1'b0, 1'b1, 1'b0);
        step();
        drive_idle();
        mem_rdata = 32'h8877_6655;
        step();
        n_cmp++;
        if (rsp_err !== 1'b1 || rsp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL orphan: err=%b valid=%b want 1/0", rsp_err, rsp_valid);
        end
        step();
        n_cmp++;
        if (rsp_err !== 1'b0) begin
            n_bad++;
            $display("FAIL orphan_pulse: err=%b want 0", rsp_err);
        end
    endtask

    task automatic test_kill();
        drive_req(OP_WORD, 2'd1, 1'b1, 1'b0, 1'b0);
        step();
        drive_idle();
        req_kill = 1'b1;
        mem_rdata = 32'h4433_2211;
        step();
        req_kill = 1'b0;
        n_cmp++;
        if (rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin
            n_bad++;
            $display("FAIL kill_quiet: valid=%b err=%b want 0/0", rsp_valid, rsp_err);
        end
        // HELD must be gone: a lone second half is now an orphan.
        drive_req(OP_WORD, 2'd1, 1'b0, 1'b1, 1'b0);
        step();
        drive_idle();
        mem_rdata = 32'h8877_6655;
        step();
        n_cmp++;
        if (rsp_err !== 1'b1 || rsp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL kill_cleared_held: err=%b valid=%b want 1/0", rsp_err, rsp_valid);
        end
        step();
    endtask

    task automatic test_reset_mid_split();
        drive_req(OP_WORD, 2'd2, 1'b1, 1'b0, 1'b0);
        step();
        drive_idle();
        mem_rdata = 32'h4433_2211;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++;
        if (rsp_valid !== 1'b0 || rsp_data !== 32'd0) begin
            n_bad++;
            $display("FAIL rst_mid_split: valid=%b data=%h want 0 00000000", rsp_valid, rsp_data);
        end
        drive_req(OP_WORD, 2'd2, 1'b0, 1'b1, 1'b0);
        step();
        drive_idle();
        mem_rdata = 32'h8877_6655;
        step();
        n_cmp++;
        if (rsp_err !== 1'b1 || rsp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_orphan: err=%b valid=%b want 1/0", rsp_err, rsp_valid);
        end
        step();
    endtask

    task automatic test_split_overwrite();
        drive_req(OP_WORD, 2'd1, 1'b1, 1'b0, 1'b0);
        step();
        drive_req(OP_WORD, 2'd2, 1'b1, 1'b0, 1'b0);
        mem_rdata = 32'h4433_2211;
        step();
        drive_req(OP_WORD, 2'd2, 1'b0, 1'b1, 1'b0);
        mem_rdata = 32'h8877_6655;
        step();
        drive_idle();
        mem_rdata = 32'hCCBB_AA99;
        n_cmp++;
        if (rsp_err !== 1'b1 || rsp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL overwrite_err: err=%b valid=%b want 1/0", rsp_err, rsp_valid);
        end
        step();
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'hAA99_8877 || rsp_err !== 1'b0) begin
            n_bad++;
            $display("FAIL overwrite_merge: valid=%b data=%h err=%b want 1 aa998877 0",
                     rsp_valid, rsp_data, rsp_err);
        end
        step();
    endtask

    task automatic test_halt_mid_split();
        drive_req(OP_WORD, 2'd1, 1'b1, 1'b0, 1'b0);
        step();
        drive_req(OP_WORD, 2'd1, 1'b0, 1'b1, 1'b0);
        mem_rdata = 32'h4433_2211;
        step();
        drive_idle();
        mem_rdata = 32'h8877_6655;
        halt = 1'b1;
        for (int i = 0; i < 3; i++) step();
        n_cmp++;
        if (rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin
            n_bad++;
            $display("FAIL halt_frozen: valid=%b err=%b want 0/0", rsp_valid, rsp_err);
        end
        halt = 1'b0;
        step();
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'h5544_3322) begin
            n_bad++;
            $display("FAIL halt_release: valid=%b data=%h want 1 55443322", rsp_valid, rsp_data);
        end
        // With clk_en low the pulse must stretch.
        clk_en = 1'b0;
        mem_rdata = 32'h0;
        step(); step();
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'h5544_3322) begin
            n_bad++;
            $display("FAIL clk_en_hold: valid=%b data=%h want 1 55443322", rsp_valid, rsp_data);
        end
        clk_en = 1'b1;
        step();
        n_cmp++;
        if (rsp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL clk_en_release: valid=%b want 0", rsp_valid);
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1; clk_en = 1'b0; halt = 1'b0; req_kill = 1'b0;
        mem_rdata = 32'd0;
        drive_idle();
        test_reset();
        test_aligned_word();
        test_back_to_back();
        test_double_aligned();
        test_split_word();
        test_split_double();
        test_sign_ext();
        test_orphan();
        test_kill();
        test_reset_mid_split();
        test_split_overwrite();
        test_halt_mid_split();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
